byte_scrambler: RTL and testbench

Byte-stream scrambler that sits directly downstream of the team's 8-bit LFSR pattern generator. It carries its own instance of the same feedback (next = {s[6:0], s[1]^s[3]^s[4]^s[6]}) and XORs each accepted data byte with the current LFSR state. The LFSR reseeds at every start-of-frame. Input and output use valid/ready handshakes, with a 2-entry output buffer and per-frame framing checks.

---
 rtl/scr_pkg.sv | 17 +
 rtl/byte_scrambler_if.sv | 17 +
 rtl/scr_skid_fifo.sv | 43 ++++
 rtl/byte_scrambler.sv | 61 ++++++
 tb/tb_byte_scrambler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/scr_pkg.sv
// scr_pkg: shared LFSR constants, step function, beat struct and FSM states for byte_scrambler.
package scr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAPS = 8'b0101_1010;
  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;
  typedef enum logic {IDLE, IN_FRAME} state_t;
  // Zero is a lockup state for this feedback, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {s[LFSR_W-2:0], ^(s & TAPS)};
    return (n == '0) ? LFSR_W'(1) : n;
  endfunction
endpackage

// File: rtl/byte_scrambler_if.sv
// byte_scrambler_if: valid/ready input and output beat streams of byte_scrambler.
interface byte_scrambler_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_eof;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  modport slave (input in_valid, in_data, in_sof, in_eof, out_ready,
                 output in_ready, out_valid, out_data, out_sof, out_eof);
  modport master (output in_valid, in_data, in_sof, in_eof, out_ready,
                  input in_ready, out_valid, out_data, out_sof, out_eof);
endinterface

// File: rtl/scr_skid_fifo.sv
// scr_skid_fifo: 2-entry beat FIFO with registered not-full flag.
module scr_skid_fifo import scr_pkg::*; (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  beat_t push_beat,
  input  logic  pop_ready,
  output logic  valid,
  output beat_t pop_beat,
  output logic  not_full
);
  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic       wr_q, wr_d, rd_q, rd_d, nf_q, nf_d, pop;
  logic [1:0] cnt_q, cnt_d;
  assign valid    = cnt_q != 2'd0;
  assign pop_beat = mem_q[rd_q];
  assign not_full = nf_q;
  always_comb begin
    pop = valid & pop_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_beat;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    nf_d = cnt_d != 2'd2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
      nf_q  <= 1'b1;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      nf_q  <= nf_d;
    end
  end
endmodule

// File: rtl/byte_scrambler.sv
// byte_scrambler: framed LFSR byte scrambler with per-SOF reseed and a 2-entry output buffer.
module byte_scrambler import scr_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scr_en,
  byte_scrambler_if.slave        bus,
  output logic [15:0]            frame_cnt,
  output logic                   err_pulse
);
  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, key;
  logic              frame_en_q, frame_en_d, err_q, err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              accept, push, en;
  beat_t             push_beat, out_beat;
  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    push = accept & (bus.in_sof | state_q == IN_FRAME);
    key = bus.in_sof ? SEED : lfsr_q;
    en = bus.in_sof ? scr_en : frame_en_q;
    push_beat = '{data: bus.in_data ^ (en ? key : 8'h00), sof: bus.in_sof, eof: bus.in_eof};
    state_d = push ? (bus.in_eof ? IDLE : IN_FRAME) : state_q;
    lfsr_d = push ? lfsr_step(key) : lfsr_q;
    frame_en_d = (accept & bus.in_sof) ? scr_en : frame_en_q;
    frame_cnt_d = frame_cnt_q + 16'(push & bus.in_eof);
    // Stray beat in IDLE and SOF inside a frame are both framing errors.
    err_d = accept & (bus.in_sof == (state_q == IN_FRAME));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      frame_en_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      frame_en_q  <= frame_en_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end
  scr_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_beat (push_beat),
    .pop_ready (bus.out_ready),
    .valid     (bus.out_valid),
    .pop_beat  (out_beat),
    .not_full  (bus.in_ready)
  );
  assign bus.out_data = out_beat.data;
  assign bus.out_sof  = out_beat.sof;
  assign bus.out_eof  = out_beat.eof;
  assign frame_cnt    = frame_cnt_q;
  assign err_pulse    = err_q;
endmodule

// File: tb/tb_byte_scrambler.sv
// tb_byte_scrambler: scoreboard bench for byte_scrambler (SEED=01 and SEED=80 instances).
module tb_byte_scrambler;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        en0 = 0, en1 = 0;
  logic [15:0] fc0, fc1;
  logic        err0, err1;
  int          checks = 0, failures = 0;
  logic [9:0]  q0[$], q1[$];
  byte_scrambler_if b0();
  byte_scrambler_if b1();
  byte_scrambler #(.SEED(8'h01)) u0 (.clk(clk), .rst_n(rst_n), .scr_en(en0), .bus(b0), .frame_cnt(fc0), .err_pulse(err0));
  byte_scrambler #(.SEED(8'h80)) u1 (.clk(clk), .rst_n(rst_n), .scr_en(en1), .bus(b1), .frame_cnt(fc1), .err_pulse(err1));
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && b0.out_valid && b0.out_ready) begin
    checks++;
    if (q0.size() == 0) begin
      failures++;
      $display("FAIL out0_extra got %h required none", {b0.out_data, b0.out_sof, b0.out_eof});
    end else begin
      logic [9:0] e;
      e = q0.pop_front();
      if ({b0.out_data, b0.out_sof, b0.out_eof} !== e) begin
        failures++;
        $display("FAIL out0_beat got %h/%b%b required %h/%b%b", b0.out_data, b0.out_sof, b0.out_eof, e[9:2], e[1], e[0]);
      end
    end
  end
  always @(negedge clk) if (rst_n && b1.out_valid && b1.out_ready) begin
    checks++;
    if (q1.size() == 0) begin
      failures++;
      $display("FAIL out1_extra got %h required none", {b1.out_data, b1.out_sof, b1.out_eof});
    end else begin
      logic [9:0] e;
      e = q1.pop_front();
      if ({b1.out_data, b1.out_sof, b1.out_eof} !== e) begin
        failures++;
        $display("FAIL out1_beat got %h/%b%b required %h/%b%b", b1.out_data, b1.out_sof, b1.out_eof, e[9:2], e[1], e[0]);
      end
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic s, input logic e, input logic en, input logic pe, input logic [7:0] x);
    b0.in_valid = 1; b0.in_data = d; b0.in_sof = s; b0.in_eof = e; en0 = en;
    for (int i = 0; i < 50 && !b0.in_ready; i++) @(posedge clk) #1;
    if (!b0.in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout got in_ready=0 required 1");
    end
    if (pe) q0.push_back({x, s, e});
    @(posedge clk) #1;
    b0.in_valid = 0; b0.in_sof = 0; b0.in_eof = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk) #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end
    repeat (2) @(posedge clk) #1;
  endtask
  task automatic check_cnt(input string n, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", n, got, req);
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({b0.in_ready, b0.out_valid, b0.out_data, b0.out_sof, b0.out_eof, err0} !== 13'b1_0_00000000_0_0_0) begin
      failures++;
      $display("FAIL reset_out0 got %b required 1000000000000", {b0.in_ready, b0.out_valid, b0.out_data, b0.out_sof, b0.out_eof, err0});
    end
    checks++;
    if ({b1.in_ready, b1.out_valid, b1.out_data, b1.out_sof, b1.out_eof, err1} !== 13'b1_0_00000000_0_0_0) begin
      failures++;
      $display("FAIL reset_out1 got %b required 1000000000000", {b1.in_ready, b1.out_valid, b1.out_data, b1.out_sof, b1.out_eof, err1});
    end
    check_cnt("reset_fc0", fc0, 0);
  endtask
  task automatic test_basic();
    logic [7:0] k[5] = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14};
    b0.out_ready = 1;
    for (int i = 0; i < 5; i++) send(8'h00, i == 0, i == 4, 1, 1, k[i]);
    check_cnt("basic_fc", fc0, 1);
    drain();
  endtask
  task automatic test_reseed();
    logic [7:0] k[5] = '{8'hFE, 8'hFD, 8'hFA, 8'hF5, 8'hEB};
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++) send(8'hFF, i == 0, i == 4, 1, 1, k[i]);
    check_cnt("reseed_fc", fc0, 3);
    drain();
  endtask
  task automatic test_passthru();
    logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] k[3] = '{8'h01, 8'h02, 8'h05};
    for (int i = 0; i < 4; i++) send(d[i], i == 0, i == 3, i >= 2, 1, d[i]);
    for (int i = 0; i < 3; i++) send(8'h00, i == 0, i == 2, 1, 1, k[i]);
    check_cnt("passthru_fc", fc0, 5);
    drain();
  endtask
  task automatic test_lockup();
    logic [7:0] k[3] = '{8'h80, 8'h01, 8'h02};
    b1.out_ready = 1; en1 = 1;
    for (int i = 0; i < 3; i++) begin
      b1.in_valid = 1; b1.in_data = 8'h00; b1.in_sof = i == 0; b1.in_eof = i == 2;
      q1.push_back({k[i], i == 0, i == 2});
      @(posedge clk) #1;
    end
    b1.in_valid = 0; b1.in_sof = 0; b1.in_eof = 0;
    check_cnt("lockup_fc", fc1, 1);
    drain();
  endtask
  task automatic test_backpressure();
    logic [7:0] k[5] = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14};
    b0.out_ready = 0;
    send(8'h00, 1, 0, 1, 1, k[0]);
    send(8'h00, 0, 0, 1, 1, k[1]);
    checks++;
    if (b0.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready got %b required 0", b0.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b0.out_valid, b0.out_data, b0.out_sof, b0.out_eof} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold got %b/%h/%b%b required 1/01/10", b0.out_valid, b0.out_data, b0.out_sof, b0.out_eof);
      end
      @(posedge clk) #1;
    end
    b0.out_ready = 1;
    for (int i = 2; i < 5; i++) send(8'h00, 0, i == 4, 1, 1, k[i]);
    check_cnt("bp_fc", fc0, 6);
    drain();
  endtask
  task automatic test_errors();
    logic [7:0] k[5] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h05};
    send(8'h55, 0, 0, 1, 0, 8'h00);
    checks++;
    if (err0 !== 1'b1) begin failures++; $display("FAIL err_idle got %b required 1", err0); end
    @(posedge clk) #1;
    checks++;
    if (err0 !== 1'b0) begin failures++; $display("FAIL err_idle_len got %b required 0", err0); end
    send(8'h00, 1, 0, 1, 1, k[0]);
    send(8'h00, 0, 0, 1, 1, k[1]);
    send(8'h00, 1, 0, 1, 1, k[2]);
    checks++;
    if (err0 !== 1'b1) begin failures++; $display("FAIL err_sof got %b required 1", err0); end
    send(8'h00, 0, 0, 1, 1, k[3]);
    checks++;
    if (err0 !== 1'b0) begin failures++; $display("FAIL err_sof_len got %b required 0", err0); end
    send(8'h00, 0, 1, 1, 1, k[4]);
    check_cnt("err_fc", fc0, 7);
    drain();
  endtask
  task automatic test_reset_mid();
    b0.out_ready = 0;
    send(8'h00, 1, 0, 1, 1, 8'h01);
    send(8'h00, 0, 0, 1, 1, 8'h02);
    #2 rst_n = 0;
    #1;
    q0.delete();
    test_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    b0.out_ready = 1;
    send(8'h00, 1, 1, 1, 1, 8'h01);
    check_cnt("rst_fc", fc0, 1);
    drain();
  endtask
  initial begin
    {b0.in_valid, b0.in_data, b0.in_sof, b0.in_eof, b0.out_ready} = '0;
    {b1.in_valid, b1.in_data, b1.in_sof, b1.in_eof, b1.out_ready} = '0;
    repeat (2) @(posedge clk);
    #1 test_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    test_basic();
    test_reseed();
    test_passthru();
    test_lockup();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
